voting_machine_multi: RTL
=========================

# voting_machine_multi

Parameterised N-candidate voting machine, the successor to the fixed three-candidate counter in the same ballot-unit design.
- Counts single-candidate button releases with a configurable post-vote lockout.
- Rejects ambiguous (multi-button) and overflowing votes with explicit pulses.
- When voting closes, runs a sequential tally that publishes per-candidate counts, the total, the winner index and a tie flag.

## Interface
- N_CAND, 4, number of candidates (2..16)
- CNT_W, 16, per-candidate counter width (2..32); counters saturate at 2^CNT_W-1
- HOLD_CYCLES, 15, lockout length in cycles after any accepted or rejected vote (1..255)
- Derived: IDX_W = $clog2(N_CAND); TOT_W = CNT_W+IDX_W
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- i_candidate  in  N_CAND  vote buttons; bit k = candidate k
- i_voting_over  in  1  high = close voting and publish results
- o_count  out  N_CAND*CNT_W  published counts; candidate k at [k*CNT_W +: CNT_W]
- o_total  out  TOT_W  published sum of all counts
- o_winner  out  IDX_W  index of highest count (lowest index among equals)
- o_tie  out  1  more than one candidate holds the maximum count
- o_valid  out  1  published results valid (high only in DONE)
- o_vote_ack  out  1  one-cycle pulse: vote accepted and counted
- o_vote_reject  out  1  one-cycle pulse: release rejected (multi-button or saturated)

## Operation
- **Reset (rst=0 at a clock edge).**
  - State becomes IDLE.
  - Internal counters, hold counter, tally registers and the previous-sample register `prev` clear to 0.
  - All outputs clear to 0.
  - Reset wins over every other condition, in every state.
- **Release detection.**
  - `prev` samples i_candidate every non-reset cycle, in all states.
  - rel = prev & ~i_candidate (falling edge per bit).
- **States:**
  - **IDLE**
    - Clears internal counters.
    - Goes to VOTE on the next cycle.
    - Published outputs (except o_valid) keep their last values.
  - **VOTE**
    - i_voting_over=1 → TALLY. This takes priority; any rel in the same cycle is ignored.
    - Else, exactly one rel bit k set, and count[k] below max → count[k]+=1, o_vote_ack=1, go to HOLD.
    - Else, exactly one rel bit k set, and count[k] saturated → no change, o_vote_reject=1, go to HOLD.
    - Else, ≥2 rel bits set → no change, o_vote_reject=1, go to HOLD.
    - Else (rel=0) → stay in VOTE.
  - **HOLD**
    - All rel is ignored and discarded, not deferred.
    - i_voting_over=1 → TALLY immediately.
    - Otherwise returns to VOTE after exactly HOLD_CYCLES cycles in HOLD.
  - **TALLY**
    - Scans index i = 0..N_CAND-1, one per cycle.
    - Accumulates the total.
    - count[i] > best → best=count[i], win=i, tie=0.
    - count[i] == best with i>0 → tie=1.
    - Initial values: best=count[0], win=0, tie=0.
    - Runs to completion even if i_voting_over drops.
    - After the last index → DONE.
  - **DONE**
    - On entry, o_count, o_total, o_winner and o_tie are loaded and o_valid=1, all in the same edge.
    - Stays in DONE while i_voting_over=1.
    - i_voting_over=0 → IDLE; o_valid clears on that edge.
- **Widths and boundaries.**
  - The total cannot overflow, because TOT_W ≥ CNT_W+IDX_W.
  - All counts zero → winner 0, tie=1.
  - Votes are never counted in TALLY or DONE.

## Timing
- Button sampled high at edge t-1 and low at edge t, in VOTE:
  - Counter updated at edge t.
  - o_vote_ack/o_vote_reject high for the cycle after edge t.
  - HOLD entered at edge t.
  - VOTE re-entered at edge t+HOLD_CYCLES.
  - Earliest next countable release is sampled at edge t+HOLD_CYCLES+1.
- i_voting_over sampled high at edge t, in VOTE or HOLD:
  - TALLY entered at t.
  - DONE and results valid from edge t+N_CAND.
- DONE exit: i_voting_over sampled low at edge t → IDLE and o_valid=0 at t; VOTE at t+1.
- Button held through reset: `prev`=0 during reset, so its first post-reset falling edge counts normally.
- Ack and reject are never high in the same cycle.

## Test plan
- **Reset:** rst=0 for 3 cycles mid-VOTE with counts nonzero → all outputs 0. After release, VOTE is reached 1 cycle after IDLE.
- **Basic count** (N_CAND=4, HOLD_CYCLES=15): release c2 three times and c0 once, 20 cycles apart, then assert over → after 4 cycles o_count={0,3,0,1} (c3..c0), o_total=4, o_winner=2, o_tie=0, o_valid=1.
- **Reject and lockout:**
  - Release c0 and c1 in the same cycle → reject pulse, counts unchanged.
  - Release c3 8 cycles after an accepted c1 vote → no ack, c3 count stays 0.
- **Tie:** c1 and c3 get 2 votes each → o_winner=1, o_tie=1. With no votes at all → o_winner=0, o_tie=1.
- **Saturation** (CNT_W=2): 5 valid c0 votes → acks on the first 3, rejects on the 4th and 5th, o_count[c0]=3.
- **Mid-operation events:**
  - rst=0 during TALLY → outputs all 0, state IDLE.
  - over dropped mid-TALLY → o_valid high for exactly 1 cycle, then IDLE.

Source files
------------

// File: rtl/voting_machine_multi.sv
// voting_machine_multi
// N-candidate ballot unit. Counts single-button releases with a post-vote
// lockout, rejects ambiguous or saturating releases, and on close of voting
// runs a one-candidate-per-cycle tally that publishes counts, the total, the
// winning index and a tie flag.
module voting_machine_multi #(
    parameter int N_CAND      = 4,
    parameter int CNT_W       = 16,
    parameter int HOLD_CYCLES = 15,
    localparam int IDX_W      = $clog2(N_CAND),
    localparam int TOT_W      = CNT_W + IDX_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CAND-1:0]         i_candidate,
    input  logic                      i_voting_over,
    output logic [N_CAND*CNT_W-1:0]   o_count,
    output logic [TOT_W-1:0]          o_total,
    output logic [IDX_W-1:0]          o_winner,
    output logic                      o_tie,
    output logic                      o_valid,
    output logic                      o_vote_ack,
    output logic                      o_vote_reject
);

    // Machine phases
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_VOTE  = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_TALLY = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [7:0]       HOLD_END = 8'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CAND - 1);

    // Position of the set bit in a one-hot vector (last set bit if several)
    function automatic logic [IDX_W-1:0] onehot_index(input logic [N_CAND-1:0] v);
        logic [IDX_W-1:0] r;
        r = {IDX_W{1'b0}};
        for (int k = 0; k < N_CAND; k++) begin
            if (v[k]) begin
                r = IDX_W'(k);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Registered state
    logic [2:0]        state_r;
    logic [N_CAND-1:0] prev_r;
    logic [CNT_W-1:0]  cnt_r [N_CAND];
    logic [7:0]        hold_r;
    logic [IDX_W-1:0]  idx_r;
    logic [CNT_W-1:0]  best_r;
    logic [IDX_W-1:0]  win_r;
    logic              tie_r;
    logic [TOT_W-1:0]  tot_r;

    // Combinational helpers
    logic [N_CAND-1:0] rel_s;
    logic              rel_any_s;
    logic              rel_multi_s;
    logic              rel_one_s;
    logic [IDX_W-1:0]  rel_idx_s;
    logic [CNT_W-1:0]  sel_cnt_s;
    logic              sel_sat_s;
    logic [CNT_W-1:0]  scan_cnt_s;
    logic [TOT_W-1:0]  tot_next_s;
    logic [CNT_W-1:0]  best_next_s;
    logic [IDX_W-1:0]  win_next_s;
    logic              tie_next_s;
    logic              scan_last_s;

    // Release detection and classification of the released button set
    always_comb begin
        rel_s       = prev_r & ~i_candidate;
        rel_any_s   = (rel_s != {N_CAND{1'b0}});
        // clearing the lowest set bit leaves something only if >= 2 bits were set
        rel_multi_s = ((rel_s & (rel_s - N_CAND'(1))) != {N_CAND{1'b0}});
        rel_one_s   = rel_any_s && !rel_multi_s;
        rel_idx_s   = onehot_index(rel_s);
        sel_cnt_s   = cnt_r[rel_idx_s];
        sel_sat_s   = (sel_cnt_s == CNT_MAX);
    end

    // One tally step: fold the candidate at idx_r into total, best, winner, tie
    always_comb begin
        scan_cnt_s  = cnt_r[idx_r];
        tot_next_s  = tot_r + {{IDX_W{1'b0}}, scan_cnt_s};
        scan_last_s = (idx_r == IDX_LAST);
        best_next_s = best_r;
        win_next_s  = win_r;
        tie_next_s  = tie_r;
        if (scan_cnt_s > best_r) begin
            best_next_s = scan_cnt_s;
            win_next_s  = idx_r;
            tie_next_s  = 1'b0;
        end else if ((scan_cnt_s == best_r) && (idx_r != {IDX_W{1'b0}})) begin
            tie_next_s  = 1'b1;
        end else begin
            tie_next_s  = tie_r;
        end
    end

    // Main sequencer: counting, lockout, tally and result publication
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            prev_r        <= {N_CAND{1'b0}};
            for (int k = 0; k < N_CAND; k++) begin
                cnt_r[k]  <= {CNT_W{1'b0}};
            end
            hold_r        <= 8'd0;
            idx_r         <= {IDX_W{1'b0}};
            best_r        <= {CNT_W{1'b0}};
            win_r         <= {IDX_W{1'b0}};
            tie_r         <= 1'b0;
            tot_r         <= {TOT_W{1'b0}};
            o_count       <= {(N_CAND*CNT_W){1'b0}};
            o_total       <= {TOT_W{1'b0}};
            o_winner      <= {IDX_W{1'b0}};
            o_tie         <= 1'b0;
            o_valid       <= 1'b0;
            o_vote_ack    <= 1'b0;
            o_vote_reject <= 1'b0;
        end else begin
            prev_r        <= i_candidate;
            o_vote_ack    <= 1'b0;
            o_vote_reject <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    for (int k = 0; k < N_CAND; k++) begin
                        cnt_r[k] <= {CNT_W{1'b0}};
                    end
                    state_r <= ST_VOTE;
                end
                ST_VOTE: begin
                    if (i_voting_over) begin
                        // closing wins over any release seen this cycle
                        idx_r   <= {IDX_W{1'b0}};
                        best_r  <= cnt_r[0];
                        win_r   <= {IDX_W{1'b0}};
                        tie_r   <= 1'b0;
                        tot_r   <= {TOT_W{1'b0}};
                        state_r <= ST_TALLY;
                    end else if (rel_one_s) begin
                        if (!sel_sat_s) begin
                            cnt_r[rel_idx_s] <= sel_cnt_s + CNT_W'(1);
                            o_vote_ack       <= 1'b1;
                        end else begin
                            o_vote_reject    <= 1'b1;
                        end
                        hold_r  <= 8'd0;
                        state_r <= ST_HOLD;
                    end else if (rel_multi_s) begin
                        o_vote_reject <= 1'b1;
                        hold_r        <= 8'd0;
                        state_r       <= ST_HOLD;
                    end else begin
                        state_r <= ST_VOTE;
                    end
                end
                ST_HOLD: begin
                    // releases during lockout are dropped, not queued
                    if (i_voting_over) begin
                        idx_r   <= {IDX_W{1'b0}};
                        best_r  <= cnt_r[0];
                        win_r   <= {IDX_W{1'b0}};
                        tie_r   <= 1'b0;
                        tot_r   <= {TOT_W{1'b0}};
                        state_r <= ST_TALLY;
                    end else if (hold_r == HOLD_END) begin
                        state_r <= ST_VOTE;
                    end else begin
                        hold_r  <= hold_r + 8'd1;
                    end
                end
                ST_TALLY: begin
                    tot_r  <= tot_next_s;
                    best_r <= best_next_s;
                    win_r  <= win_next_s;
                    tie_r  <= tie_next_s;
                    if (scan_last_s) begin
                        // publish the final step's values directly so results
                        // appear on the same edge that enters DONE
                        for (int k = 0; k < N_CAND; k++) begin
                            o_count[k*CNT_W +: CNT_W] <= cnt_r[k];
                        end
                        o_total  <= tot_next_s;
                        o_winner <= win_next_s;
                        o_tie    <= tie_next_s;
                        o_valid  <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        idx_r    <= idx_r + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!i_voting_over) begin
                        o_valid <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
